// File: rtl/aligner_pkg.sv
// Shared types and defaults for the multi-channel data aligner.
// The status encoding is exported directly on statuses_o.
package aligner_pkg;

   typedef enum logic [1:0] {
      ST_OK    = 2'b00,
      ST_EMPTY = 2'b01,
      ST_FULL  = 2'b10,
      ST_OVF   = 2'b11
   } status_e;

   localparam int DEF_N_CH   = 2;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_DEPTH  = 8;

   // Overflow outranks full, and full outranks empty.
   function automatic status_e fifo_status(input logic ovf, input logic full, input logic empty);
      status_e st;
      st = ST_OK;
      if (ovf)
         st = ST_OVF;
      else if (full)
         st = ST_FULL;
      else if (empty)
         st = ST_EMPTY;
      return st;
   endfunction

endpackage

// File: rtl/aligner_fifo.sv
// Per-channel FIFO with a sticky overflow flag. The storage array has no reset,
// so it can map onto flops or distributed RAM.
module aligner_fifo
   import aligner_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic                       clk,
   input  logic                       areset,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic                       clr_ovf,
   input  logic [DATA_W-1:0]          din,
   output logic [DATA_W-1:0]          dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic                       ovf
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              pop_ok;
   logic              push_ok;
   logic              ovf_set;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

   // A pop on the same edge frees the slot that a push into a full FIFO needs.
   assign pop_ok  = pop & ~empty & ~flush;
   assign push_ok = push & (~full | pop_ok) & ~flush;
   assign ovf_set = push & full & ~pop_ok & ~flush;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push_ok)
               wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)
               rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
         end
         // A fresh overflow beats a same-edge clear.
         if (ovf_set)
            ovf <= 1'b1;
         else if (clr_ovf)
            ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= din;
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/multi_ch_data_aligner.sv
// Aligns N_CH independent write streams into one output word set; a set is
// released only once every channel FIFO holds at least one word.
module multi_ch_data_aligner
   import aligner_pkg::*;
#(
   parameter int N_CH   = DEF_N_CH,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     areset,
   input  logic [N_CH*DATA_W-1:0]   data_i,
   input  logic [N_CH-1:0]          vld_i,
   input  logic                     flush_i,
   input  logic                     clr_ovf_i,
   input  logic                     rdy_i,
   output logic [N_CH*DATA_W-1:0]   data_o,
   output logic                     vld_o,
   output logic [2*N_CH-1:0]        statuses_o
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0]      dout [N_CH];
   logic [CW-1:0]          count [N_CH];
   logic [N_CH-1:0]        full;
   logic [N_CH-1:0]        empty;
   logic [N_CH-1:0]        ovf;
   logic [N_CH-1:0]        nonempty;
   logic [N_CH*DATA_W-1:0] head_word;
   logic                   load;

   // Status depends only on FIFO flops, never on vld_i or rdy_i.
   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      aligner_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .clk     (clk),
         .areset  (areset),
         .push    (vld_i[c]),
         .pop     (load),
         .flush   (flush_i),
         .clr_ovf (clr_ovf_i),
         .din     (data_i[c*DATA_W +: DATA_W]),
         .dout    (dout[c]),
         .count   (count[c]),
         .full    (full[c]),
         .empty   (empty[c]),
         .ovf     (ovf[c])
      );

      assign nonempty[c]                   = (count[c] != '0);
      assign head_word[c*DATA_W +: DATA_W] = dout[c];
      assign statuses_o[2*c +: 2]          = fifo_status(ovf[c], full[c], empty[c]);
   end

   assign load = (&nonempty) & (~vld_o | rdy_i) & ~flush_i;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         data_o <= '0;
         vld_o  <= 1'b0;
      end else if (flush_i) begin
         data_o <= '0;
         vld_o  <= 1'b0;
      end else if (load) begin
         data_o <= head_word;
         vld_o  <= 1'b1;
      end else if (rdy_i) begin
         vld_o  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_multi_ch_data_aligner.sv
// Directed bench for the two-channel, depth-8 aligner with hand-computed expectations.
module tb_multi_ch_data_aligner;

   logic        clk = 1'b0;
   logic        areset;
   logic [63:0] data_i;
   logic [1:0]  vld_i;
   logic        flush_i;
   logic        clr_ovf_i;
   logic        rdy_i;
   logic [63:0] data_o;
   logic        vld_o;
   logic [3:0]  statuses_o;

   int          n_chk = 0;
   int          n_err = 0;
   logic [63:0] exp_q [$];
   int          vld_cnt;
   int          gaps;
   logic        seen_vld;
   logic        seen_drop;
   logic [63:0] held;

   multi_ch_data_aligner #(
      .N_CH   (2),
      .DATA_W (32),
      .DEPTH  (8)
   ) dut (
      .clk        (clk),
      .areset     (areset),
      .data_i     (data_i),
      .vld_i      (vld_i),
      .flush_i    (flush_i),
      .clr_ovf_i  (clr_ovf_i),
      .rdy_i      (rdy_i),
      .data_o     (data_o),
      .vld_o      (vld_o),
      .statuses_o (statuses_o)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // A word leaves on an edge where vld_o and rdy_i are both high; check it first.
   task automatic tick();
      logic [63:0] e;
      if (vld_o && rdy_i) begin
         check_val("out_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_val("out_data", data_o, e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] v, input logic [31:0] d1, input logic [31:0] d0);
      vld_i  = v;
      data_i = {d1, d0};
   endtask

   task automatic track();
      if (vld_o) begin
         if (seen_drop)
            gaps++;
         vld_cnt++;
         seen_vld = 1'b1;
      end else if (seen_vld) begin
         seen_drop = 1'b1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      areset    = 1'b1;
      flush_i   = 1'b0;
      clr_ovf_i = 1'b0;
      rdy_i     = 1'b0;
      drive(2'b00, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_vld", 64'(vld_o), 64'd0);
      check_val("rst_data", data_o, 64'd0);
      check_val("rst_status", 64'(statuses_o), 64'h5);
      areset = 1'b0;

      // Late second channel: release one edge after it arrives.
      drive(2'b01, 32'h0, 32'hA0);
      tick();
      drive(2'b00, 32'h0, 32'h0);
      tick();
      tick();
      check_val("r031_wait_vld", 64'(vld_o), 64'd0);
      check_val("r031_wait_st", 64'(statuses_o), 64'h4);
      drive(2'b10, 32'hB0, 32'h0);
      tick();
      check_val("r031_no_bypass", 64'(vld_o), 64'd0);
      drive(2'b00, 32'h0, 32'h0);
      tick();
      check_val("r031_vld", 64'(vld_o), 64'd1);
      check_val("r031_data", data_o, 64'h000000B0_000000A0);
      check_val("r031_status", 64'(statuses_o), 64'h5);
      exp_q.push_back(64'h000000B0_000000A0);
      rdy_i = 1'b1;
      tick();
      check_val("r031_vld_clear", 64'(vld_o), 64'd0);

      // Overflow on channel 0 while channel 1 stays idle.
      for (int i = 0; i < 8; i++) begin
         drive(2'b01, 32'h0, 32'(32'h100 + i));
         tick();
      end
      check_val("r032_full", 64'(statuses_o), 64'h6);
      drive(2'b01, 32'h0, 32'h108);
      tick();
      check_val("r032_ovf", 64'(statuses_o), 64'h7);
      drive(2'b01, 32'h0, 32'h109);
      clr_ovf_i = 1'b1;
      tick();
      check_val("r023_ovf_wins", 64'(statuses_o), 64'h7);
      drive(2'b00, 32'h0, 32'h0);
      tick();
      clr_ovf_i = 1'b0;
      check_val("r032_clr_ovf", 64'(statuses_o), 64'h6);
      for (int k = 0; k < 8; k++) begin
         exp_q.push_back({32'(32'h200 + k), 32'(32'h100 + k)});
         drive(2'b10, 32'(32'h200 + k), 32'h0);
         tick();
      end
      drive(2'b00, 32'h0, 32'h0);
      repeat (4) tick();
      check_val("r032_drained", 64'(exp_q.size()), 64'd0);
      check_val("r032_status_end", 64'(statuses_o), 64'h5);

      // Sustained streaming through pointer wrap.
      vld_cnt   = 0;
      gaps      = 0;
      seen_vld  = 1'b0;
      seen_drop = 1'b0;
      for (int k = 0; k < 32; k++) begin
         exp_q.push_back({32'(k), 32'(k)});
         drive(2'b11, 32'(k), 32'(k));
         tick();
         track();
      end
      drive(2'b00, 32'h0, 32'h0);
      repeat (4) begin
         tick();
         track();
      end
      check_val("r033_vld_cycles", 64'(vld_cnt), 64'd32);
      check_val("r033_gaps", 64'(gaps), 64'd0);
      check_val("r033_drained", 64'(exp_q.size()), 64'd0);

      // Backpressure: output holds while both FIFOs fill.
      rdy_i = 1'b0;
      for (int i = 0; i < 9; i++) begin
         exp_q.push_back({32'(32'h300 + i), 32'(32'h300 + i)});
         drive(2'b11, 32'(32'h300 + i), 32'(32'h300 + i));
         tick();
         if (i == 1)
            held = data_o;
         if (i >= 1) begin
            check_val("r034_hold_vld", 64'(vld_o), 64'd1);
            check_val("r034_hold_data", data_o, 64'h00000300_00000300);
            check_val("r034_stable", data_o, held);
         end
      end
      check_val("r034_full", 64'(statuses_o), 64'hA);
      drive(2'b00, 32'h0, 32'h0);
      rdy_i = 1'b1;
      repeat (12) tick();
      check_val("r034_drained", 64'(exp_q.size()), 64'd0);
      check_val("r034_status_end", 64'(statuses_o), 64'h5);

      // Full channel 0 takes a push on the same edge it is popped.
      for (int i = 0; i < 8; i++) begin
         drive(2'b01, 32'h0, 32'(32'h400 + i));
         tick();
      end
      check_val("r035_full", 64'(statuses_o), 64'h6);
      drive(2'b10, 32'h500, 32'h0);
      tick();
      check_val("r035_ch1_one", 64'(statuses_o), 64'h2);
      exp_q.push_back(64'h00000500_00000400);
      drive(2'b01, 32'h0, 32'h408);
      tick();
      check_val("r035_push_pop", 64'(statuses_o), 64'h6);
      check_val("r035_vld", 64'(vld_o), 64'd1);
      for (int k = 1; k < 9; k++) begin
         exp_q.push_back({32'(32'h500 + k), 32'(32'h400 + k)});
         drive(2'b10, 32'(32'h500 + k), 32'h0);
         tick();
      end
      drive(2'b00, 32'h0, 32'h0);
      repeat (4) tick();
      check_val("r035_drained", 64'(exp_q.size()), 64'd0);
      check_val("r035_no_ovf", 64'(statuses_o), 64'h5);

      // Asynchronous reset mid-stream.
      rdy_i = 1'b0;
      drive(2'b11, 32'h600, 32'h600);
      tick();
      drive(2'b11, 32'h601, 32'h601);
      tick();
      drive(2'b00, 32'h0, 32'h0);
      check_val("r036_pre_vld", 64'(vld_o), 64'd1);
      #3 areset = 1'b1;
      #1;
      check_val("r036_rst_vld", 64'(vld_o), 64'd0);
      check_val("r036_rst_data", data_o, 64'd0);
      check_val("r036_rst_status", 64'(statuses_o), 64'h5);
      exp_q.delete();
      @(posedge clk);
      #1;
      areset = 1'b0;
      rdy_i  = 1'b1;
      exp_q.push_back(64'h00000700_00000700);
      drive(2'b11, 32'h700, 32'h700);
      tick();
      drive(2'b00, 32'h0, 32'h0);
      tick();
      check_val("r036_post_rst_vld", 64'(vld_o), 64'd1);
      tick();
      check_val("r036_post_rst_drained", 64'(exp_q.size()), 64'd0);

      // Flush with a same-edge push.
      rdy_i = 1'b0;
      drive(2'b11, 32'h800, 32'h800);
      tick();
      drive(2'b11, 32'h801, 32'h801);
      tick();
      check_val("r036_pre_flush_vld", 64'(vld_o), 64'd1);
      flush_i = 1'b1;
      drive(2'b11, 32'h802, 32'h802);
      tick();
      flush_i = 1'b0;
      drive(2'b00, 32'h0, 32'h0);
      check_val("r036_flush_vld", 64'(vld_o), 64'd0);
      check_val("r036_flush_status", 64'(statuses_o), 64'h5);
      tick();
      check_val("r036_flush_discard", 64'(vld_o), 64'd0);
      check_val("r036_flush_empty", 64'(statuses_o), 64'h5);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
